led_breath_scheduler: RTL and testbench
=======================================

# led_breath_scheduler

Mode controller and channel scheduler for the YRGB LED breathing datapath. Contains its own triangle-ramp PWM duty generator. Accepts mode commands over a valid/ready handshake and decides which of the four board LEDs the PWM drives: all off, all breathing, one-at-a-time chase, or blink. Mode changes take effect only on breath-cycle boundaries, so the LEDs never glitch. Sits between the board-control logic (buttons/UART decoder) and the `yrgb_led` pins.

## Interface
- `PWM_PERIOD`, default 3464: clock cycles per PWM frame and number of duty levels. Must be ≥2. Breath cycle = 2·PWM_PERIOD² cycles (≈2 s at 12 MHz).
- `clk`  in  1  system clock, 12 MHz
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  mode command present
- `cmd_mode`  in  2  requested mode: 00 OFF, 01 BREATHE, 10 CHASE, 11 BLINK
- `cmd_ready`  out  1  command can be accepted; equals ~pending
- `yrgb_led`  out  4  LED drive, active-low (0 = lit), registered
- `cur_mode`  out  2  mode currently applied
- `active_ch`  out  2  LED index driven in CHASE; 0 in other modes
- `cycle_done`  out  1  one-cycle pulse at each breath-cycle boundary

## Operation
- Counter widths: `fcnt` and `duty` are $clog2(PWM_PERIOD) bits; `dir` is 1 bit (0 = up).
- Frame counter `fcnt` runs 0..P-1 and wraps. `frame_end` = (fcnt == P-1).
- Duty ramp, updated only on `frame_end`:
  - up, duty < P-1: duty+1
  - up, duty == P-1: dir ← down, duty held
  - down, duty > 0: duty-1
  - down, duty == 0: dir ← up, duty held; this is the **boundary** event
- Per-frame duty sequence for P=4: 0,1,2,3,3,2,1,0, then repeats.
- `lit` = (fcnt < duty).
- While `cur_mode` == OFF, the generator is held at fcnt=0, duty=0, dir=up.
- LED map (before the output register):
  - OFF: 4'hF
  - BREATHE: all four bits = ~lit
  - CHASE: bit[active_ch] = ~lit, other bits 1
  - BLINK: 4'h0 while dir=up, 4'hF while dir=down
- Command handshake:
  - Transfer happens when cmd_valid && cmd_ready.
  - On transfer, `pending_mode` ← cmd_mode and `pending` ← 1.
  - Only one command can be pending; cmd_ready stays low until it is applied.
- Apply rules:
  - On boundary with pending=1: cur_mode ← pending_mode, pending ← 0, active_ch ← 0, generator continues from duty 0 up.
  - On boundary with pending=0 and cur_mode = CHASE: active_ch ← active_ch+1, wrapping 3→0.
  - If cur_mode = OFF and pending = 1: apply on the next clock without waiting for a boundary. The generator starts counting the cycle after that.
- `cycle_done` pulses for every boundary, including one where a mode is applied. It never pulses in OFF.
- Commanding the same mode as the current one is legal. It is applied at the boundary, which also restarts CHASE at channel 0.

## Timing
- Reset values:
  - cur_mode = OFF, pending = 0, cmd_ready = 1
  - yrgb_led = 4'hF, active_ch = 0, cycle_done = 0
  - fcnt = 0, duty = 0, dir = up
- `yrgb_led` and `cycle_done` are registered: 1-cycle latency from the fcnt/duty/mode state.
- `cmd_ready` falls the cycle after a transfer.
- A transfer in the same cycle as a boundary is not applied at that boundary. It waits for the next one, a full breath cycle later.
- Command latency from OFF: transfer at cycle T, cur_mode updates at T+2, first possible lit LED at T+3.
- Command latency from a non-OFF mode: up to 2·P² + 2 cycles.
- Reset asserted mid-cycle or with a command pending: everything returns to reset values immediately and the pending command is discarded.

## Test plan
Use PWM_PERIOD = 4, giving a breath cycle of 32 cycles.
- **Reset:** hold rst 3 cycles, then release with cmd_valid=0 → yrgb_led=4'hF, cmd_ready=1, cur_mode=00 for 100 cycles, cycle_done never pulses.
- **BREATHE from OFF:** cmd_mode=01 for one cycle → cur_mode=01 two cycles later. Over each 32-cycle breath, each LED bit is low for exactly 12 cycles, with per-frame low counts 0,1,2,3,3,2,1,0. cycle_done pulses every 32 cycles.
- **CHASE rotation:** command 10 from OFF → active_ch steps 0,1,2,3,0 at consecutive cycle_done pulses. Only bit[active_ch] is ever 0; other bits stay 1.
- **Mid-cycle change:** in BREATHE, send 11 ten cycles after a boundary → cmd_ready low until the next boundary (22 cycles later), then cur_mode=11. yrgb_led=4'h0 for 16 cycles, then 4'hF for 16 cycles.
- **Back-pressure and collision:** hold cmd_valid high with cmd_mode=10 while pending → only one transfer. A second command issued in the boundary cycle → applied 32 cycles later, not at that boundary.
- **Reset mid-operation:** assert rst during CHASE with active_ch=2 and a command pending → all outputs at reset values the following cycle. After release the pending mode is never applied.

Source files
------------

// File: rtl/led_breath_scheduler.sv
// Mode controller and channel scheduler for the YRGB breathing LEDs, with a built-in
// triangle-ramp PWM generator; mode changes land only on breath-cycle boundaries.
module led_breath_scheduler #(
  parameter int PWM_PERIOD = 3464
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  output logic [3:0] yrgb_led,
  output logic [1:0] cur_mode,
  output logic [1:0] active_ch,
  output logic       cycle_done
);

  localparam int W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [W-1:0] TOP = W'(PWM_PERIOD - 1);
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BREATHE = 2'b01,
    MODE_CHASE   = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  mode_e        cur_mode_q, cur_mode_d;
  mode_e        pending_mode_q, pending_mode_d;
  logic         pending_q, pending_d;
  logic [W-1:0] fcnt_q, fcnt_d;
  logic [W-1:0] duty_q, duty_d;
  logic         dir_q, dir_d;
  logic [1:0]   active_ch_q, active_ch_d;
  logic [3:0]   led_q, led_d;
  logic         cycle_done_q, cycle_done_d;

  logic frame_end;
  logic boundary;
  logic lit;
  logic xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode_q     <= MODE_OFF;
      pending_mode_q <= MODE_OFF;
      pending_q      <= 1'b0;
      fcnt_q         <= '0;
      duty_q         <= '0;
      dir_q          <= DIR_UP;
      active_ch_q    <= 2'd0;
      led_q          <= 4'hF;
      cycle_done_q   <= 1'b0;
    end else begin
      cur_mode_q     <= cur_mode_d;
      pending_mode_q <= pending_mode_d;
      pending_q      <= pending_d;
      fcnt_q         <= fcnt_d;
      duty_q         <= duty_d;
      dir_q          <= dir_d;
      active_ch_q    <= active_ch_d;
      led_q          <= led_d;
      cycle_done_q   <= cycle_done_d;
    end
  end

  always_comb begin
    frame_end      = (fcnt_q == TOP);
    boundary       = (cur_mode_q != MODE_OFF) && frame_end &&
                     (dir_q == DIR_DOWN) && (duty_q == '0);
    lit            = (fcnt_q < duty_q);
    xfer           = cmd_valid && !pending_q;

    cur_mode_d     = cur_mode_q;
    pending_mode_d = pending_mode_q;
    pending_d      = pending_q;
    fcnt_d         = fcnt_q;
    duty_d         = duty_q;
    dir_d          = dir_q;
    active_ch_d    = active_ch_q;
    led_d          = 4'hF;
    cycle_done_d   = boundary;

    // Triangle ramp: the duty level steps once per PWM frame, turning round at both ends.
    if (cur_mode_q == MODE_OFF) begin
      fcnt_d = '0;
      duty_d = '0;
      dir_d  = DIR_UP;
    end else begin
      fcnt_d = frame_end ? '0 : fcnt_q + W'(1);
      if (frame_end) begin
        if (dir_q == DIR_UP) begin
          if (duty_q == TOP) dir_d  = DIR_DOWN;
          else               duty_d = duty_q + W'(1);
        end else begin
          if (duty_q == '0) dir_d  = DIR_UP;
          else              duty_d = duty_q - W'(1);
        end
      end
    end

    // A pending command and a new transfer never coexist, so these cannot collide.
    if (cur_mode_q == MODE_OFF && pending_q) begin
      cur_mode_d  = pending_mode_q;
      pending_d   = 1'b0;
      active_ch_d = 2'd0;
    end else if (boundary) begin
      if (pending_q) begin
        cur_mode_d  = pending_mode_q;
        pending_d   = 1'b0;
        active_ch_d = 2'd0;
      end else if (cur_mode_q == MODE_CHASE) begin
        active_ch_d = active_ch_q + 2'd1;
      end
    end

    if (xfer) begin
      pending_d      = 1'b1;
      pending_mode_d = mode_e'(cmd_mode);
    end

    case (cur_mode_q)
      MODE_BREATHE: led_d = {4{~lit}};
      MODE_CHASE: begin
        led_d              = 4'hF;
        led_d[active_ch_q] = ~lit;
      end
      MODE_BLINK:   led_d = (dir_q == DIR_UP) ? 4'h0 : 4'hF;
      default:      led_d = 4'hF;
    endcase
  end

  assign cmd_ready  = ~pending_q;
  assign yrgb_led   = led_q;
  assign cur_mode   = cur_mode_q;
  assign active_ch  = active_ch_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breath_scheduler.sv
// Directed self-checking bench for led_breath_scheduler with PWM_PERIOD = 4 (32-cycle breath).
module tb_led_breath_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'b00;
  logic       cmd_ready;
  logic [3:0] yrgb_led;
  logic [1:0] cur_mode;
  logic [1:0] active_ch;
  logic       cycle_done;

  int tests = 0;
  int fails = 0;
  int dseq [8] = '{0, 1, 2, 3, 3, 2, 1, 0};

  led_breath_scheduler #(.PWM_PERIOD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_ready (cmd_ready),
    .yrgb_led  (yrgb_led),
    .cur_mode  (cur_mode),
    .active_ch (active_ch),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit low_at(input int i);
    return (i % 4) < dseq[(i % 32) / 4];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_from_off(input logic [1:0] m);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) tick();
    tests++; if (yrgb_led !== 4'hF) begin fails++; $display("FAIL reset_led got %h want f", yrgb_led); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    tests++; if (cur_mode !== 2'b00) begin fails++; $display("FAIL reset_mode got %b want 00", cur_mode); end
    tests++; if (active_ch !== 2'd0) begin fails++; $display("FAIL reset_ch got %0d want 0", active_ch); end
    tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL reset_cd got %b want 0", cycle_done); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++; if (yrgb_led !== 4'hF) begin fails++; $display("FAIL idle_led cyc %0d got %h want f", i, yrgb_led); end
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_ready cyc %0d got %b want 1", i, cmd_ready); end
      tests++; if (cur_mode !== 2'b00) begin fails++; $display("FAIL idle_mode cyc %0d got %b want 00", i, cur_mode); end
      tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL idle_cd cyc %0d got %b want 0", i, cycle_done); end
    end
  endtask

  task automatic test_breathe();
    int lows;
    logic [3:0] exp_led;
    do_reset();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    tick();
    cmd_valid = 1'b0;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL br_ready_after_xfer got %b want 0", cmd_ready); end
    tests++; if (cur_mode !== 2'b00) begin fails++; $display("FAIL br_mode_t1 got %b want 00", cur_mode); end
    tick();
    tests++; if (cur_mode !== 2'b01) begin fails++; $display("FAIL br_mode_t2 got %b want 01", cur_mode); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL br_ready_t2 got %b want 1", cmd_ready); end
    lows = 0;
    for (int i = 0; i < 96; i++) begin
      tick();
      exp_led = low_at(i) ? 4'h0 : 4'hF;
      if (yrgb_led[0] === 1'b0) lows++;
      tests++; if (yrgb_led !== exp_led) begin fails++; $display("FAIL br_led smp %0d got %h want %h", i, yrgb_led, exp_led); end
      tests++; if (cycle_done !== (i % 32 == 31)) begin fails++; $display("FAIL br_cd smp %0d got %b want %b", i, cycle_done, (i % 32 == 31)); end
      if (i % 32 == 31) begin
        tests++; if (lows != 12) begin fails++; $display("FAIL br_low_count smp %0d got %0d want 12", i, lows); end
        lows = 0;
      end
    end
  endtask

  task automatic test_chase();
    logic [3:0] exp_led;
    logic [1:0] exp_ch;
    int ch;
    do_reset();
    start_from_off(2'b10);
    tests++; if (cur_mode !== 2'b10) begin fails++; $display("FAIL ch_mode got %b want 10", cur_mode); end
    tests++; if (active_ch !== 2'd0) begin fails++; $display("FAIL ch_start got %0d want 0", active_ch); end
    for (int i = 0; i < 160; i++) begin
      tick();
      ch = (i / 32) % 4;
      exp_led = 4'hF;
      if (low_at(i)) exp_led[ch] = 1'b0;
      exp_ch = 2'(((i + 1) / 32) % 4);
      tests++; if (yrgb_led !== exp_led) begin fails++; $display("FAIL ch_led smp %0d got %h want %h", i, yrgb_led, exp_led); end
      tests++; if (active_ch !== exp_ch) begin fails++; $display("FAIL ch_idx smp %0d got %0d want %0d", i, active_ch, exp_ch); end
      tests++; if (cycle_done !== (i % 32 == 31)) begin fails++; $display("FAIL ch_cd smp %0d got %b want %b", i, cycle_done, (i % 32 == 31)); end
    end
  endtask

  task automatic test_mid_change();
    int n;
    logic [3:0] exp_led;
    do_reset();
    start_from_off(2'b01);
    n = 0;
    while (n < 40 && cycle_done !== 1'b1) begin
      tick();
      n++;
    end
    tests++; if (n != 32) begin fails++; $display("FAIL mid_first_boundary got %0d cycles want 32", n); end
    repeat (9) tick();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b11;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_before got %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_after got %b want 0", cmd_ready); end
    for (int k = 0; k < 21; k++) begin
      tick();
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_hold cyc %0d got %b want 0", k, cmd_ready); end
      tests++; if (cur_mode !== 2'b01) begin fails++; $display("FAIL mid_mode_hold cyc %0d got %b want 01", k, cur_mode); end
    end
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_applied got %b want 1", cmd_ready); end
    tests++; if (cur_mode !== 2'b11) begin fails++; $display("FAIL mid_mode_applied got %b want 11", cur_mode); end
    tests++; if (cycle_done !== 1'b1) begin fails++; $display("FAIL mid_cd_applied got %b want 1", cycle_done); end
    for (int j = 0; j < 32; j++) begin
      tick();
      exp_led = (j < 16) ? 4'h0 : 4'hF;
      tests++; if (yrgb_led !== exp_led) begin fails++; $display("FAIL blink_led smp %0d got %h want %h", j, yrgb_led, exp_led); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int xfers;
    do_reset();
    start_from_off(2'b01);
    cmd_valid = 1'b1;
    cmd_mode  = 2'b10;
    n = 0;
    xfers = 0;
    while (n < 40) begin
      if (cmd_valid && cmd_ready) xfers++;
      tick();
      n++;
      if (cur_mode === 2'b10) break;
    end
    cmd_valid = 1'b0;
    tests++; if (n != 32) begin fails++; $display("FAIL b2b_apply_latency got %0d want 32", n); end
    tests++; if (xfers != 1) begin fails++; $display("FAIL b2b_transfers got %0d want 1", xfers); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", cmd_ready); end
    tests++; if (active_ch !== 2'd0) begin fails++; $display("FAIL b2b_ch got %0d want 0", active_ch); end
    repeat (31) tick();
    tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL col_cd_pre got %b want 0", cycle_done); end
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL col_ready_pre got %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    tests++; if (cycle_done !== 1'b1) begin fails++; $display("FAIL col_cd got %b want 1", cycle_done); end
    tests++; if (cur_mode !== 2'b10) begin fails++; $display("FAIL col_mode_not_applied got %b want 10", cur_mode); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL col_ready got %b want 0", cmd_ready); end
    tests++; if (active_ch !== 2'd1) begin fails++; $display("FAIL col_ch got %0d want 1", active_ch); end
    for (int k = 0; k < 31; k++) begin
      tick();
      tests++; if (cur_mode !== 2'b10) begin fails++; $display("FAIL col_mode_hold cyc %0d got %b want 10", k, cur_mode); end
    end
    tick();
    tests++; if (cur_mode !== 2'b01) begin fails++; $display("FAIL col_mode_applied got %b want 01", cur_mode); end
    tests++; if (active_ch !== 2'd0) begin fails++; $display("FAIL col_ch_applied got %0d want 0", active_ch); end
    tests++; if (cycle_done !== 1'b1) begin fails++; $display("FAIL col_cd_applied got %b want 1", cycle_done); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL col_ready_applied got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_from_off(2'b10);
    repeat (64) tick();
    tests++; if (active_ch !== 2'd2) begin fails++; $display("FAIL rm_ch got %0d want 2", active_ch); end
    repeat (5) tick();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b11;
    tick();
    cmd_valid = 1'b0;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rm_pending got %b want 0", cmd_ready); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (yrgb_led !== 4'hF) begin fails++; $display("FAIL rm_async_led got %h want f", yrgb_led); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rm_async_ready got %b want 1", cmd_ready); end
    tests++; if (cur_mode !== 2'b00) begin fails++; $display("FAIL rm_async_mode got %b want 00", cur_mode); end
    tests++; if (active_ch !== 2'd0) begin fails++; $display("FAIL rm_async_ch got %0d want 0", active_ch); end
    tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL rm_async_cd got %b want 0", cycle_done); end
    tick();
    tests++; if (yrgb_led !== 4'hF) begin fails++; $display("FAIL rm_led got %h want f", yrgb_led); end
    tests++; if (active_ch !== 2'd0) begin fails++; $display("FAIL rm_ch_after got %0d want 0", active_ch); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++; if (cur_mode !== 2'b00) begin fails++; $display("FAIL rm_post_mode cyc %0d got %b want 00", i, cur_mode); end
      tests++; if (yrgb_led !== 4'hF) begin fails++; $display("FAIL rm_post_led cyc %0d got %h want f", i, yrgb_led); end
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rm_post_ready cyc %0d got %b want 1", i, cmd_ready); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_breathe();
    test_chase();
    test_mid_change();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
